// File: rtl/rle_codec_stream.sv
// rle_codec_stream
//   Run-length compression / decompression engine with valid/ready streams.
//   COMPRESS turns a framed symbol stream into {count,symbol} pairs, capping
//   each run at MAX_RUN. DECOMPRESS expands pairs back into symbol beats.
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   command               00 NOP, 01 COMPRESS, 10 DECOMPRESS, 11 ABORT
//   data_*                raw symbol input stream (valid/last/ready)
//   compressed_in, comp_in_*   pair input stream
//   compressed_out, comp_out_* registered pair output stream
//   decompressed_out, decomp_* registered symbol output stream
//   response              00 IDLE, 01 BUSY, 10 DONE, 11 ERROR
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for COMPRESS / DECOMPRESS
// COMP      | accepting symbols, accumulating runs
// COMP_TAIL | last symbol broke the run; emit {1,last_sym} with last
// DECOMP    | accepting pairs, replaying symbol beats
// DONE      | frame finished, response DONE for one cycle
// ERR       | zero-count pair seen; wait for ABORT or reset
module rle_codec_stream #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 4,
   parameter int PAIR_WIDTH  = DATA_WIDTH + COUNT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            command,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   input  logic                  data_last,
   output logic                  data_ready,
   input  logic [PAIR_WIDTH-1:0] compressed_in,
   input  logic                  comp_in_valid,
   input  logic                  comp_in_last,
   output logic                  comp_in_ready,
   output logic [PAIR_WIDTH-1:0] compressed_out,
   output logic                  comp_out_valid,
   output logic                  comp_out_last,
   input  logic                  comp_out_ready,
   output logic [DATA_WIDTH-1:0] decompressed_out,
   output logic                  decomp_valid,
   output logic                  decomp_last,
   input  logic                  decomp_ready,
   output logic [1:0]            response
);

   typedef enum logic [2:0] {
      S_IDLE, S_COMP, S_COMP_TAIL, S_DECOMP, S_DONE, S_ERR
   } state_t;

   localparam logic [1:0] CMD_COMP   = 2'b01;
   localparam logic [1:0] CMD_DECOMP = 2'b10;
   localparam logic [1:0] CMD_ABORT  = 2'b11;

   localparam logic [COUNT_WIDTH-1:0] MAX_RUN = {COUNT_WIDTH{1'b1}};
   localparam logic [COUNT_WIDTH-1:0] ONE     = COUNT_WIDTH'(1);

   state_t                 state, state_n;
   logic [DATA_WIDTH-1:0]  sym_r;
   logic [COUNT_WIDTH-1:0] cnt_r;
   logic                   have_run;
   logic [COUNT_WIDTH-1:0] rem_r;
   logic                   pair_last_r;

   logic                   data_acc, pair_acc, beat_acc, comp_last_acc;
   logic                   comp_slot_free, run_extends;
   logic [COUNT_WIDTH-1:0] pair_cnt, cnt_inc, rem_dec;

   assign data_acc       = data_valid && data_ready;
   assign pair_acc       = comp_in_valid && comp_in_ready;
   assign beat_acc       = decomp_valid && decomp_ready;
   assign comp_last_acc  = comp_out_valid && comp_out_last && comp_out_ready;
   assign comp_slot_free = !comp_out_valid || comp_out_ready;
   assign pair_cnt       = compressed_in[PAIR_WIDTH-1:DATA_WIDTH];
   assign cnt_inc        = cnt_r + ONE;
   assign rem_dec        = rem_r - ONE;
   assign run_extends    = have_run && (data_in == sym_r) && (cnt_r != MAX_RUN);

   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_n;
   end

   // Readies and response; readies drop during ABORT so nothing is consumed.
   always_comb begin
      data_ready    = 1'b0;
      comp_in_ready = 1'b0;
      response      = 2'b00;
      case (state)
         S_COMP: begin
            response   = 2'b01;
            // Once the final pair is registered, no more symbols belong to this frame.
            data_ready = (command != CMD_ABORT) &&
                         (!comp_out_valid || (comp_out_ready && !comp_out_last));
         end
         S_COMP_TAIL: response = 2'b01;
         S_DECOMP: begin
            response      = 2'b01;
            // rem_r counts beats not yet accepted, so zero also means the slot is empty.
            comp_in_ready = (command != CMD_ABORT) && (rem_r == '0);
         end
         S_DONE:  response = 2'b10;
         S_ERR:   response = 2'b11;
         default: response = 2'b00;
      endcase
   end

   always_comb begin
      state_n = state;
      if (command == CMD_ABORT) begin
         state_n = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (command == CMD_COMP)        state_n = S_COMP;
               else if (command == CMD_DECOMP) state_n = S_DECOMP;
            end
            S_COMP: begin
               if (comp_last_acc) state_n = S_DONE;
               else if (data_acc && data_last && have_run && !run_extends)
                  state_n = S_COMP_TAIL;
            end
            S_COMP_TAIL: if (comp_last_acc) state_n = S_DONE;
            S_DECOMP: begin
               if (pair_acc && (pair_cnt == '0))   state_n = S_ERR;
               else if (beat_acc && decomp_last)   state_n = S_DONE;
            end
            S_DONE:  state_n = S_IDLE;
            S_ERR:   state_n = S_ERR;
            default: state_n = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sym_r            <= '0;
         cnt_r            <= '0;
         have_run         <= 1'b0;
         rem_r            <= '0;
         pair_last_r      <= 1'b0;
         compressed_out   <= '0;
         comp_out_valid   <= 1'b0;
         comp_out_last    <= 1'b0;
         decompressed_out <= '0;
         decomp_valid     <= 1'b0;
         decomp_last      <= 1'b0;
      end else if (command == CMD_ABORT) begin
         cnt_r          <= '0;
         have_run       <= 1'b0;
         rem_r          <= '0;
         comp_out_valid <= 1'b0;
         comp_out_last  <= 1'b0;
         decomp_valid   <= 1'b0;
         decomp_last    <= 1'b0;
      end else begin
         if (comp_out_valid && comp_out_ready) begin
            comp_out_valid <= 1'b0;
            comp_out_last  <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               cnt_r    <= '0;
               have_run <= 1'b0;
               rem_r    <= '0;
            end
            S_COMP: begin
               if (data_acc) begin
                  if (run_extends) begin
                     if (data_last) begin
                        compressed_out <= {cnt_inc, data_in};
                        comp_out_valid <= 1'b1;
                        comp_out_last  <= 1'b1;
                        have_run       <= 1'b0;
                        cnt_r          <= '0;
                     end else begin
                        cnt_r <= cnt_inc;
                     end
                  end else if (!have_run) begin
                     if (data_last) begin
                        compressed_out <= {ONE, data_in};
                        comp_out_valid <= 1'b1;
                        comp_out_last  <= 1'b1;
                     end else begin
                        sym_r    <= data_in;
                        cnt_r    <= ONE;
                        have_run <= 1'b1;
                     end
                  end else begin
                     // Run broken or saturated: flush the held run, keep the new symbol.
                     compressed_out <= {cnt_r, sym_r};
                     comp_out_valid <= 1'b1;
                     comp_out_last  <= 1'b0;
                     sym_r          <= data_in;
                     if (data_last) begin
                        have_run <= 1'b0;
                        cnt_r    <= '0;
                     end else begin
                        cnt_r <= ONE;
                     end
                  end
               end
            end
            S_COMP_TAIL: begin
               // sym_r holds the final symbol; emit it once the slot frees.
               if (!(comp_out_valid && comp_out_last) && comp_slot_free) begin
                  compressed_out <= {ONE, sym_r};
                  comp_out_valid <= 1'b1;
                  comp_out_last  <= 1'b1;
               end
            end
            S_DECOMP: begin
               if (beat_acc) begin
                  rem_r <= rem_dec;
                  if (rem_r == ONE) begin
                     decomp_valid <= 1'b0;
                     decomp_last  <= 1'b0;
                  end else begin
                     decomp_last <= pair_last_r && (rem_dec == ONE);
                  end
               end
               if (pair_acc && (pair_cnt != '0)) begin
                  rem_r            <= pair_cnt;
                  decompressed_out <= compressed_in[DATA_WIDTH-1:0];
                  decomp_valid     <= 1'b1;
                  decomp_last      <= comp_in_last && (pair_cnt == ONE);
                  pair_last_r      <= comp_in_last;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/rle_codec_stream.md
Name: rle_codec_stream

Overview:
- Parametrised run-length compression/decompression engine. It is the next generation of the comp_if-based compression block.
- Adds a clock, valid/ready handshakes, framing via "last", configurable symbol and run-count widths, and error reporting.
- Sits between the stimulus driver and the reference-model checker. Either compresses a symbol stream into {count,symbol} pairs or expands pairs back into symbols.

Parameters:
- DATA_WIDTH, 8, symbol width in bits.
- COUNT_WIDTH, 4, run-count field width. Maximum run is MAX_RUN = 2^COUNT_WIDTH-1.
- PAIR_WIDTH, DATA_WIDTH+COUNT_WIDTH, derived; must not be overridden. Pair format is {count[COUNT_WIDTH-1:0], symbol[DATA_WIDTH-1:0]}.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- command  in  2  00 NOP, 01 COMPRESS, 10 DECOMPRESS, 11 ABORT.
- data_in  in  DATA_WIDTH  raw symbol input.
- data_valid / data_last  in  1  raw input qualifiers.
- data_ready  out  1  raw input accept.
- compressed_in  in  PAIR_WIDTH  pair input.
- comp_in_valid / comp_in_last  in  1  pair input qualifiers.
- comp_in_ready  out  1  pair input accept.
- compressed_out  out  PAIR_WIDTH  registered pair output.
- comp_out_valid / comp_out_last  out  1  pair output qualifiers.
- comp_out_ready  in  1  downstream accept.
- decompressed_out  out  DATA_WIDTH  registered symbol output.
- decomp_valid / decomp_last  out  1  symbol output qualifiers.
- decomp_ready  in  1  downstream accept.
- response  out  2  00 IDLE, 01 BUSY, 10 DONE, 11 ERROR.

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - All outputs are 0: data, valids, lasts, readies, response.
  - Run/remaining counters are cleared.
  - Reset overrides everything, including mid-frame; partial runs are discarded.
- Transfer rule: a transfer occurs when valid && ready at a clk edge. An output's valid, data and last stay stable until accepted.
- States: IDLE, COMP, COMP_TAIL, DECOMP, DONE, ERR.
- IDLE: command 01 goes to COMP, 10 goes to DECOMP; others are ignored. response=00.
- Command handling outside IDLE:
  - 11 (ABORT) in any state goes to IDLE next cycle and clears output valids and the counters.
  - 01/10 are ignored outside IDLE.
- COMP (response=01):
  - data_ready = !comp_out_valid || comp_out_ready.
  - On an accepted symbol with no run held: load sym_r=data_in, cnt_r=1.
  - If data_in==sym_r and cnt_r<MAX_RUN: cnt_r++.
  - Otherwise: register output {cnt_r,sym_r} with comp_out_valid=1 on the next cycle, then load the new symbol with cnt_r=1.
  - Output appears 1 cycle after the run-breaking accept.
- Last symbol in COMP (data_last=1):
  - If it extends the run without saturation: emit {cnt_r+1,sym} with comp_out_last=1, then go to DONE after the handshake.
  - If it breaks the run, or cnt_r==MAX_RUN: emit the held run (last=0), then go to COMP_TAIL.
  - If it is the first symbol: emit {1,sym} with last=1.
- COMP_TAIL: data_ready=0. Emits {1,last_sym} with last=1 once the output slot frees, then goes to DONE after the handshake.
- DECOMP (response=01):
  - comp_in_ready=1 only when remaining==0 and the output slot is free or draining.
  - An accepted pair loads rem=count, sym.
  - decompressed_out=sym is valid 1 cycle after the accept. rem decrements on each accepted output beat.
  - decomp_last=1 on the final beat of a pair that arrived with comp_in_last.
  - After that beat is accepted, go to DONE.
- Zero-count pair: response=11 next cycle, go to ERR, pair dropped, no output beat.
- ERR: all readies 0, valids 0, response=11. Holds until ABORT or reset.
- DONE: response=10 for exactly one cycle, then IDLE.
- Runs never exceed MAX_RUN. Counts are unsigned; no wrap of cnt_r is permitted.

Test Plan:
1. COMPRESS, DATA_WIDTH=8/COUNT_WIDTH=4, input AA,AA,AA,BB(last), ready=1 -> pairs {3,AA},{1,BB,last}; response 01…01,10 for one cycle, then 00.
2. COMPRESS, 17×0x55 with last on the 17th -> {15,55},{2,55,last}; no run exceeds 15.
3. COMPRESS, single symbol 0x09 with last -> {1,09,last}, then DONE one cycle.
4. DECOMPRESS, pairs {3,7E},{1,01,last}, decomp_ready toggling 1/0 -> 7E,7E,7E,01(last); value held stable during stalls; comp_in_ready low while rem>0.
5. DECOMPRESS, pair {0,33} -> response=11 next cycle, comp_in_ready=0, no decomp_valid; command 11 -> response 00, IDLE next cycle.
6. reset=0 during COMP with cnt_r=5 pending -> next edge: all valids/readies 0, response 00; fresh COMPRESS of CC(last) -> {1,CC,last} (no stale run).
